membus_rr_arbiter: RTL and testbench
====================================

# membus_rr_arbiter

Three-port round-robin arbiter that shares the single main-memory bus between the instruction cache, the data cache and an auxiliary master (DMA / debug loader). It replaces the fixed two-port bus controller sitting in front of `Memory`. The arbiter keeps exactly one memory transaction outstanding, routes each response back to its originator, and can lock the bus to one requester for atomic read-modify-write sequences.

## Interface
- `ADDR_WIDTH`, 32: request address width.
- `DATA_WIDTH`, 32: read and write data width.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 3: per-requester request valid (bit0 icache, bit1 dcache, bit2 aux).
- `req_ready` out 3: per-requester accept, one-hot or zero.
- `req_addr` in 3×ADDR_WIDTH: per-requester address.
- `req_wen` in 3: per-requester write enable.
- `req_wdata` in 3×DATA_WIDTH: per-requester write data.
- `req_lock` in 3: holds the grant on this requester after its transaction completes.
- `resp_valid` out 3: per-requester response pulse.
- `resp_rdata` out DATA_WIDTH: response data, shared by all requesters, meaningful only with `resp_valid`.
- `mem_req_valid` out 1: request to memory.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_addr` out ADDR_WIDTH: memory request address.
- `mem_req_wen` out 1: memory write enable.
- `mem_req_wdata` out DATA_WIDTH: memory write data.
- `mem_resp_valid` in 1: memory response; memory returns exactly one for every accepted request, reads and writes alike.
- `mem_resp_rdata` in DATA_WIDTH: memory response data.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - Winner = first requester with `req_valid` set, scanning from `rr_ptr` upward modulo 3.
  - If `locked`, only `lock_owner` is eligible.
  - `req_ready[winner]` is driven combinationally in the same cycle.
  - On that handshake: latch addr, wen, wdata and grant; go to ISSUE.
- **ISSUE**
  - `mem_req_valid`=1 with the latched fields.
  - Fields stay stable until `mem_req_ready`; then go to WAIT.
- **WAIT**
  - On `mem_resp_valid`: register `mem_resp_rdata` into `resp_rdata`; pulse `resp_valid[grant]` for exactly 1 cycle, one cycle later; go to IDLE.
  - `rr_ptr` ← (grant+1) mod 3.
  - `locked` ← `req_lock[grant]` sampled at the response; `lock_owner` ← grant.
- Lock is released when the owner completes a transaction with `req_lock`=0, or when the owner is in IDLE with `req_valid`=0 and `req_lock`=0.
- `mem_resp_valid` in IDLE or ISSUE is spurious: ignored, no `resp_valid`.
- Requester fields that change after the `req_ready` handshake have no effect.
- Reset, including mid-transaction:
  - state IDLE, `rr_ptr`=0, `locked`=0, `resp_valid`=0.
  - all `mem_req_*` outputs 0, `resp_rdata`=0.
  - an in-flight response is discarded.

## Timing
- Accept at cycle T.
- `mem_req_valid` from T+1.
- Memory accepts at T+1+W.
- Memory responds at T+1+W+L, with L≥1.
- `resp_valid` at T+2+W+L.
- Earliest next accept is the same cycle as `resp_valid` (the FSM is back in IDLE).
- Minimum spacing between accepts is 3 cycles (W=0, L=1).
- `req_ready` is combinational from `req_valid`, `rr_ptr` and lock state. All other outputs are registered.
- Fairness: with all three requesters continuously valid and no lock, grants rotate 0,1,2,0,…; no requester waits more than 2 foreign transactions.

## Structure
- `MemBusReq`/`MemBusResp` typedefs and the requester-index constants (`MB_ICACHE`=0, `MB_DCACHE`=1, `MB_AUX`=2) live in the shared memory-interface package.
- FSM state enum is local.
- One sub-module, `rr_pick3`: combinational next-winner selection from valid, pointer and lock mask.

## Test plan
- Reset, then only dcache requests read 0x100 with memory L=1 → `req_ready`=3'b010 at T, `mem_req_addr`=0x100 at T+1, `resp_valid`=3'b010 at T+3 with memory's rdata.
- All three valid continuously, 6 transactions → grant order 0,1,2,0,1,2; `resp_valid` one-hot each time, matching order.
- dcache holds `req_lock`=1 for 3 requests while icache also requests → 3 consecutive dcache grants, icache granted next after the lock drops.
- `mem_req_ready` low 4 cycles during ISSUE → address/wen/wdata stable all 4 cycles, single memory handshake, single `resp_valid`.
- Aux write 0xDEADBEEF to 0x2000 → `mem_req_wen`=1, `mem_req_wdata`=0xDEADBEEF; `resp_valid[2]` pulses on the write response.
- `rst` asserted in WAIT, `mem_resp_valid` arrives after release → all outputs 0 immediately, no `resp_valid`; next grant uses `rr_ptr`=0.

Source files
------------

// File: rtl/membus_rr_arbiter_pkg.sv
// Shared memory-interface definitions: requester indices, bus transaction
// types and small index helpers used by the round-robin arbiter.
package membus_rr_arbiter_pkg;

  localparam int MB_N_REQ  = 3;
  localparam int MB_ADDR_W = 32;
  localparam int MB_DATA_W = 32;

  localparam logic [1:0] MB_ICACHE = 2'd0;
  localparam logic [1:0] MB_DCACHE = 2'd1;
  localparam logic [1:0] MB_AUX    = 2'd2;

  typedef struct packed {
    logic [MB_ADDR_W-1:0] addr;
    logic                 wen;
    logic [MB_DATA_W-1:0] wdata;
  } MemBusReq;

  typedef struct packed {
    logic [MB_DATA_W-1:0] rdata;
  } MemBusResp;

  // Next requester index in round-robin order (wraps aux back to icache).
  function automatic logic [1:0] mb_next_idx(input logic [1:0] idx);
    return (idx == MB_AUX) ? MB_ICACHE : idx + 2'd1;
  endfunction

  // One-hot requester vector for an index.
  function automatic logic [2:0] mb_onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/membus_rr_arbiter_pick.sv
// Combinational round-robin winner selection over three requesters: scans
// from ptr upward (mod 3) and returns the first valid, unmasked requester.
module rr_pick3
  import membus_rr_arbiter_pkg::*;
(
  input  logic [2:0] valid,
  input  logic [1:0] ptr,
  input  logic [2:0] mask,
  output logic [2:0] grant,
  output logic [1:0] idx,
  output logic       found
);

  logic [2:0] elig;
  logic [1:0] cand;

  // Walk the three candidates starting at ptr; the first eligible one wins.
  always_comb begin
    elig  = valid & mask;
    grant = '0;
    idx   = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int i = 0; i < MB_N_REQ; i++) begin
      if (!found && elig[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
      cand = mb_next_idx(cand);
    end
    if (found) grant = mb_onehot(idx);
  end

endmodule

// File: rtl/membus_rr_arbiter.sv
// Three-port round-robin arbiter for the main-memory bus. One transaction is
// outstanding at a time; responses are routed back to the granted requester,
// and a requester may lock the bus across several transactions.
module membus_rr_arbiter
  import membus_rr_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = MB_ADDR_W,
  parameter int DATA_WIDTH = MB_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 req_valid,
  output logic [2:0]                 req_ready,
  input  logic [2:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]                 req_wen,
  input  logic [2:0][DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]                 req_lock,
  output logic [2:0]                 resp_valid,
  output logic [DATA_WIDTH-1:0]      resp_rdata,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [ADDR_WIDTH-1:0]      mem_req_addr,
  output logic                       mem_req_wen,
  output logic [DATA_WIDTH-1:0]      mem_req_wdata,
  input  logic                       mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]      mem_resp_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] rr_ptr;
  logic [1:0] grant;
  logic [1:0] lock_owner;
  logic       locked;
  logic [2:0] lock_mask;
  logic [2:0] pick_grant;
  logic [1:0] pick_idx;
  logic       pick_found;
  logic       accept;
  logic       resp_done;

  // While locked only the owner may win; otherwise everyone is eligible.
  assign lock_mask = locked ? mb_onehot(lock_owner) : 3'b111;
  assign accept    = (state == IDLE) && pick_found;
  assign resp_done = (state == WAIT) && mem_resp_valid;

  rr_pick3 u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .mask  (lock_mask),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: accept -> issue until memory takes it -> wait for response.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (pick_found)     state_next = ISSUE;
      ISSUE:   if (mem_req_ready)  state_next = WAIT;
      WAIT:    if (mem_resp_valid) state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  // Requester accept is the only combinational output; offered only in IDLE.
  always_comb begin
    req_ready = '0;
    if (state == IDLE) req_ready = pick_grant;
  end

  // Latch the winning request and hold it on the memory port until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
      grant         <= MB_ICACHE;
    end else if (accept) begin
      mem_req_valid <= 1'b1;
      mem_req_addr  <= req_addr[pick_idx];
      mem_req_wen   <= req_wen[pick_idx];
      mem_req_wdata <= req_wdata[pick_idx];
      grant         <= pick_idx;
    end else if ((state == ISSUE) && mem_req_ready) begin
      mem_req_valid <= 1'b0;
    end
  end

  // Return the memory response to the granted requester as a one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= '0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= '0;
      if (resp_done) begin
        resp_valid <= mb_onehot(grant);
        resp_rdata <= mem_resp_rdata;
      end
    end
  end

  // Advance the round-robin pointer and update the lock on each completion;
  // an idle owner that drops both valid and lock also frees the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= MB_ICACHE;
      locked     <= 1'b0;
      lock_owner <= MB_ICACHE;
    end else if (resp_done) begin
      rr_ptr     <= mb_next_idx(grant);
      locked     <= req_lock[grant];
      lock_owner <= grant;
    end else if ((state == IDLE) && locked && !req_valid[lock_owner] && !req_lock[lock_owner]) begin
      locked <= 1'b0;
    end
  end

endmodule

// File: tb/tb_membus_rr_arbiter.sv
// Directed self-checking bench for membus_rr_arbiter with a small memory
// model (configurable accept stall and response latency).
module tb_membus_rr_arbiter;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       req_valid = '0;
  logic [2:0]       req_ready;
  logic [2:0][31:0] req_addr = '0;
  logic [2:0]       req_wen = '0;
  logic [2:0][31:0] req_wdata = '0;
  logic [2:0]       req_lock = '0;
  logic [2:0]       resp_valid;
  logic [31:0]      resp_rdata;
  logic             mem_req_valid;
  logic             mem_req_ready = 1'b0;
  logic [31:0]      mem_req_addr;
  logic             mem_req_wen;
  logic [31:0]      mem_req_wdata;
  logic             mem_resp_valid = 1'b0;
  logic [31:0]      mem_resp_rdata = '0;

  int total = 0;
  int bad = 0;

  int mem_stall = 0;
  int mem_lat = 1;
  int stall_left = 0;
  int lat_left = 0;
  int hs_count = 0;
  bit offered = 1'b0;
  logic [31:0] pend_addr = '0;

  logic [2:0]  accept_q[$];
  logic [2:0]  resp_q[$];
  logic [31:0] rdata_q[$];

  membus_rr_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_wen        (req_wen),
    .req_wdata      (req_wdata),
    .req_lock       (req_lock),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wen    (mem_req_wen),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: raises ready after mem_stall cycles of a pending request,
  // answers mem_lat cycles after the handshake with rdata = addr ^ 5A5A5A5A.
  // Its latency counter keeps running through reset so a late response can
  // arrive after reset is released.
  always @(negedge clk) begin
    mem_resp_valid = 1'b0;
    if (rst) begin
      mem_req_ready = 1'b0;
      offered = 1'b0;
      stall_left = mem_stall;
    end else if (offered) begin
      offered = 1'b0;
      mem_req_ready = 1'b0;
      hs_count++;
      lat_left = mem_lat;
    end else if (!mem_req_valid) begin
      stall_left = mem_stall;
    end else if (stall_left > 0) begin
      stall_left--;
    end else begin
      mem_req_ready = 1'b1;
      offered = 1'b1;
      pend_addr = mem_req_addr;
    end
    if (lat_left > 0) begin
      lat_left--;
      if (lat_left == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = pend_addr ^ 32'h5A5A_5A5A;
      end
    end
  end

  // Record every requester handshake and every response pulse.
  always @(negedge clk) begin
    if (!rst && ((req_valid & req_ready) != 3'b000)) accept_q.push_back(req_ready);
    if (resp_valid != 3'b000) begin
      resp_q.push_back(resp_valid);
      rdata_q.push_back(resp_rdata);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic valid, input logic [31:0] addr,
                               input logic wen, input logic [31:0] wdata, input logic lock);
    req_valid[idx] = valid;
    req_addr[idx]  = addr;
    req_wen[idx]   = wen;
    req_wdata[idx] = wdata;
    req_lock[idx]  = lock;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    nextCycle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic waitAccepts(input string tag, input int n);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (accept_q.size() >= n) break;
    end
    checkOutput(tag, 32'(accept_q.size() >= n), 32'd1);
  endtask

  task automatic waitResps(input string tag, input int n);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (resp_q.size() >= n) break;
    end
    checkOutput(tag, 32'(resp_q.size() >= n), 32'd1);
  endtask

  initial begin
    int ab;
    int rb;
    int hb;
    logic [2:0]  exp_rr[6];
    logic [31:0] exp_rd[6];
    logic [2:0]  exp_lk[4];

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'h0);
    checkOutput("rst_mem_valid", 32'(mem_req_valid), 32'h0);
    checkOutput("rst_mem_addr", mem_req_addr, 32'h0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);

    // Single dcache read of 0x100, memory latency 1
    nextCycle();
    applyStimulus(1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("t1_ready_T", 32'(req_ready), 32'b010);
    nextCycle();
    applyStimulus(1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("t1_mem_valid_T1", 32'(mem_req_valid), 32'h1);
    checkOutput("t1_mem_addr_T1", mem_req_addr, 32'h100);
    checkOutput("t1_mem_wen_T1", 32'(mem_req_wen), 32'h0);
    @(negedge clk);
    checkOutput("t1_resp_T2", 32'(resp_valid), 32'b000);
    @(negedge clk);
    checkOutput("t1_resp_T3", 32'(resp_valid), 32'b010);
    checkOutput("t1_rdata_T3", resp_rdata, 32'h5A5A_5B5A);
    @(negedge clk);
    checkOutput("t1_resp_T4", 32'(resp_valid), 32'b000);

    // All three continuously valid: rotation 0,1,2,0,1,2 from a fresh reset
    applyReset();
    ab = accept_q.size();
    rb = resp_q.size();
    applyStimulus(0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
    applyStimulus(1, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0);
    applyStimulus(2, 1'b1, 32'h30, 1'b0, 32'h0, 1'b0);
    waitAccepts("t2_accept_wait", ab + 6);
    nextCycle();
    req_valid = 3'b000;
    waitResps("t2_resp_wait", rb + 6);
    exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_rd = '{32'h5A5A_5A4A, 32'h5A5A_5A7A, 32'h5A5A_5A6A,
               32'h5A5A_5A4A, 32'h5A5A_5A7A, 32'h5A5A_5A6A};
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("t2_grant%0d", i), 32'(accept_q[ab+i]), 32'(exp_rr[i]));
      checkOutput($sformatf("t2_resp%0d", i), 32'(resp_q[rb+i]), 32'(exp_rr[i]));
      checkOutput($sformatf("t2_rdata%0d", i), rdata_q[rb+i], exp_rd[i]);
    end

    // dcache locks the bus for three transactions while icache waits
    applyReset();
    ab = accept_q.size();
    rb = resp_q.size();
    applyStimulus(1, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1);
    waitAccepts("t3_first_wait", ab + 1);
    nextCycle();
    applyStimulus(0, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0);
    waitAccepts("t3_third_wait", ab + 3);
    nextCycle();
    applyStimulus(1, 1'b0, 32'h500, 1'b0, 32'h0, 1'b0);
    waitAccepts("t3_fourth_wait", ab + 4);
    nextCycle();
    applyStimulus(0, 1'b0, 32'h600, 1'b0, 32'h0, 1'b0);
    waitResps("t3_resp_wait", rb + 4);
    exp_lk = '{3'b010, 3'b010, 3'b010, 3'b001};
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("t3_grant%0d", i), 32'(accept_q[ab+i]), 32'(exp_lk[i]));

    // Memory holds ready low for 4 cycles; request fields must stay put
    applyReset();
    rb = resp_q.size();
    hb = hs_count;
    mem_stall = 4;
    applyStimulus(0, 1'b1, 32'h400, 1'b1, 32'h1234_5678, 1'b0);
    @(negedge clk);
    checkOutput("t4_ready", 32'(req_ready), 32'b001);
    nextCycle();
    applyStimulus(0, 1'b0, 32'hFFFF, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t4_valid_c%0d", i), 32'(mem_req_valid), 32'h1);
      checkOutput($sformatf("t4_addr_c%0d", i), mem_req_addr, 32'h400);
      checkOutput($sformatf("t4_wen_c%0d", i), 32'(mem_req_wen), 32'h1);
      checkOutput($sformatf("t4_wdata_c%0d", i), mem_req_wdata, 32'h1234_5678);
    end
    mem_stall = 0;
    waitResps("t4_resp_wait", rb + 1);
    repeat (6) nextCycle();
    checkOutput("t4_handshakes", 32'(hs_count - hb), 32'd1);
    checkOutput("t4_resp_count", 32'(resp_q.size() - rb), 32'd1);
    checkOutput("t4_resp_who", 32'(resp_q[rb]), 32'b001);

    // Aux write of 0xDEADBEEF to 0x2000
    rb = resp_q.size();
    applyStimulus(2, 1'b1, 32'h2000, 1'b1, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    checkOutput("t5_ready", 32'(req_ready), 32'b100);
    nextCycle();
    applyStimulus(2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("t5_mem_addr", mem_req_addr, 32'h2000);
    checkOutput("t5_mem_wen", 32'(mem_req_wen), 32'h1);
    checkOutput("t5_mem_wdata", mem_req_wdata, 32'hDEAD_BEEF);
    waitResps("t5_resp_wait", rb + 1);
    checkOutput("t5_resp_who", 32'(resp_q[rb]), 32'b100);

    // dcache read moves the pointer to aux, then reset lands in WAIT
    rb = resp_q.size();
    nextCycle();
    applyStimulus(1, 1'b1, 32'h700, 1'b0, 32'h0, 1'b0);
    nextCycle();
    applyStimulus(1, 1'b0, 32'h700, 1'b0, 32'h0, 1'b0);
    waitResps("t6_pre_wait", rb + 1);
    mem_lat = 5;
    nextCycle();
    applyStimulus(1, 1'b1, 32'h800, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("t6_ready", 32'(req_ready), 32'b010);
    nextCycle();
    applyStimulus(1, 1'b0, 32'h800, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    nextCycle();
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_mem_valid", 32'(mem_req_valid), 32'h0);
    checkOutput("t6_rst_mem_addr", mem_req_addr, 32'h0);
    checkOutput("t6_rst_mem_wen", 32'(mem_req_wen), 32'h0);
    checkOutput("t6_rst_mem_wdata", mem_req_wdata, 32'h0);
    checkOutput("t6_rst_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("t6_rst_resp_rdata", resp_rdata, 32'h0);
    rb = resp_q.size();
    nextCycle();
    rst = 1'b0;
    repeat (8) nextCycle();
    checkOutput("t6_no_late_resp", 32'(resp_q.size() - rb), 32'd0);
    mem_lat = 1;
    req_valid = 3'b111;
    @(negedge clk);
    checkOutput("t6_ptr_after_rst", 32'(req_ready), 32'b001);
    nextCycle();
    req_valid = 3'b000;
    repeat (6) nextCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
